// File: rtl/alsu_arbiter.sv
// alsu_arbiter: shares one ALSU among NUM_REQ requesters with round-robin
// arbitration, one issue per cycle, and returns each result to its requester
// through an {valid, id, err} tag pipeline that matches the ALSU latency.
// Optional macro ALSU_ARB_LOCK_EN: a granted requester holding req_lock_i
// keeps the grant on the following cycle (for chained shift/rotate ops).
module alsu_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ALSU_LAT = 2,
    parameter int ID_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [3*NUM_REQ-1:0]   req_opcode_i,
    input  logic [3*NUM_REQ-1:0]   req_a_i,
    input  logic [3*NUM_REQ-1:0]   req_b_i,
    input  logic [7*NUM_REQ-1:0]   req_ctrl_i,
    input  logic [NUM_REQ-1:0]     req_lock_i,
    output logic [2:0]             alsu_opcode_o,
    output logic [2:0]             alsu_a_o,
    output logic [2:0]             alsu_b_o,
    output logic [6:0]             alsu_ctrl_o,
    input  logic [5:0]             alsu_out_i,
    output logic                   rsp_valid_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [5:0]             rsp_data_o,
    output logic                   rsp_err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;

    // ctrl field order: {cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in}
    // Idle op is bypass_A with A=0, so the ALSU produces 0.
    localparam logic [6:0] IDLE_CTRL = 7'b000_1000;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } tag_t;

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic               found;
    logic [SUM_W-1:0]   cand;
    logic               accept;
    logic               search_from_ptr;

    logic [2:0] sel_op, sel_a, sel_b;
    logic [6:0] sel_ctrl;
    logic       sel_err;

    logic [2:0] alsu_op_q, alsu_op_d;
    logic [2:0] alsu_a_q, alsu_a_d;
    logic [2:0] alsu_b_q, alsu_b_d;
    logic [6:0] alsu_ctrl_q, alsu_ctrl_d;

    tag_t tag_q [ALSU_LAT+1];

    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [5:0]      rsp_data_q;
    logic            rsp_err_q;

`ifdef ALSU_ARB_LOCK_EN
    logic lock_q, lock_d;

    // A locked owner is searched first, so it wins while it stays valid.
    assign search_from_ptr = lock_q;
    assign lock_d          = accept & req_lock_i[gnt_idx];

    // Lock flag: set when the accepted requester asks to keep the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_q <= 1'b0;
        else     lock_q <= lock_d;
    end
`else
    logic unused_lock;

    assign search_from_ptr = 1'b0;
    assign unused_lock     = ^req_lock_i;
`endif

    // Round-robin search starting after the pointer (or at it while locked).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant   = '0;
        gnt_idx = rr_ptr_q;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + SUM_W'(k) + {{IDX_W{1'b0}}, ~search_from_ptr};
            if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
            if (!found && req_valid_i[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                gnt_idx                  = cand[IDX_W-1:0];
                grant[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

    assign accept      = found;
    assign req_ready_o = grant;

    // Select the granted requester's fields and classify the op as valid/invalid.
    always_comb begin
        sel_op   = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op   = req_opcode_i[3*i +: 3];
                sel_a    = req_a_i[3*i +: 3];
                sel_b    = req_b_i[3*i +: 3];
                sel_ctrl = req_ctrl_i[7*i +: 7];
            end
        end
        sel_err = ~(sel_ctrl[3] | sel_ctrl[2]) &
                  (((sel_ctrl[5] | sel_ctrl[4]) & (sel_op[1] | sel_op[2])) |
                   (sel_op[1] & sel_op[2]));
    end

    // Next-state for pointer and issue register: granted op, else the idle op.
    always_comb begin
        rr_ptr_d    = accept ? gnt_idx : rr_ptr_q;
        alsu_op_d   = accept ? sel_op   : 3'b000;
        alsu_a_d    = accept ? sel_a    : 3'b000;
        alsu_b_d    = accept ? sel_b    : 3'b000;
        alsu_ctrl_d = accept ? sel_ctrl : IDLE_CTRL;
    end

    // Arbitration pointer and ALSU issue register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            alsu_op_q   <= 3'b000;
            alsu_a_q    <= 3'b000;
            alsu_b_q    <= 3'b000;
            alsu_ctrl_q <= IDLE_CTRL;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            alsu_op_q   <= alsu_op_d;
            alsu_a_q    <= alsu_a_d;
            alsu_b_q    <= alsu_b_d;
            alsu_ctrl_q <= alsu_ctrl_d;
        end
    end

    assign alsu_opcode_o = alsu_op_q;
    assign alsu_a_o      = alsu_a_q;
    assign alsu_b_o      = alsu_b_q;
    assign alsu_ctrl_o   = alsu_ctrl_q;

    // Tag pipeline: stage 0 is written at the accepting edge, shifts every cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this small array is reset in full because its valid bits must drop so in-flight ops are discarded.
        if (rst) begin
            for (int s = 0; s <= ALSU_LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= '{valid: accept, id: ID_W'(gnt_idx), err: sel_err};
            for (int s = 1; s <= ALSU_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Response register: pairs the oldest tag with the ALSU result now valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= tag_q[ALSU_LAT].valid;
            rsp_id_q    <= tag_q[ALSU_LAT].id;
            rsp_data_q  <= alsu_out_i;
            rsp_err_q   <= tag_q[ALSU_LAT].err;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
